asrm_mem_arbiter: RTL and testbench
===================================

// Module: asrm_mem_arbiter
// PURPOSE
//  Shares the single synchronous RAM port between the CPU data path and an external requester (debug/DMA).
//  Sequences each access through a small FSM.
//  Reduced-width CPU writes (status reduced-behaviour code) become read-modify-write cycles, so RAM bits
//  above the active width are preserved.
//  Sits between the CPU address unit and the RAM.
// PARAMETERS
//  wordsize  16  data/address width in bits; must be 8, 16, 32, 64 or 128
// PORTS
//  clk          in   1         clock; all state updates on posedge
//  reset        in   1         synchronous, active-low
//  cpu_req      in   1         CPU access request; held until cpu_ack
//  cpu_we       in   1         1 = write, 0 = read
//  cpu_width    in   2         reduced-behaviour code: 00 full, 01 32b, 10 16b, 11 8b
//  cpu_addr     in   wordsize  CPU address
//  cpu_wdata    in   wordsize  CPU write data (low bits significant when reduced)
//  cpu_rdata    out  wordsize  CPU read data, zero-extended to active width
//  cpu_ack      out  1         one-cycle completion pulse
//  ext_req      in   1         external request; always full width
//  ext_we       in   1         external write enable
//  ext_addr     in   wordsize  external address
//  ext_wdata    in   wordsize  external write data
//  ext_rdata    out  wordsize  external read data
//  ext_ack      out  1         one-cycle completion pulse
//  ram_addr     out  wordsize  RAM address
//  ram_data_out out  wordsize  RAM write data
//  ram_we       out  1         RAM write strobe
//  ram_data_in  in   wordsize  RAM read data; valid the cycle after ram_addr is presented
//  busy         out  1         high in every state except IDLE
// BEHAVIOUR
//  - Reset (reset=0 at posedge):
//    - state=IDLE; all outputs 0.
//    - Any in-flight op is aborted; no ram_we is issued afterwards.
//  - Effective width:
//    - Reduced only if the code's width < wordsize; otherwise the access is treated as full width.
//    - Examples: 01 on wordsize 16 -> full; 11 on wordsize 8 -> full.
//  - IDLE: samples requests and picks the owner.
//    - Latches owner, we, width, addr and wdata.
//    - Full read or reduced write -> RD; full write -> WR; no request -> stay in IDLE.
//  - RD: drives ram_addr with ram_we=0; next state is CAP.
//  - CAP: ram_data_in is valid.
//    - Read: rdata register <= ram_data_in masked to the effective width (upper bits 0); -> ACK.
//    - Reduced write: merge <= {ram_data_in above width, wdata within width}; -> WR.
//  - WR: drives ram_addr, ram_data_out (merge or wdata) and ram_we=1 for exactly one cycle; -> ACK.
//  - ACK: pulses the owner's ack for one cycle; -> IDLE.
//    - A request still high in the next IDLE is treated as a new access.
//  - Latency, counted in cycles from the IDLE sample to the ack pulse:
//    - read: 3
//    - full write: 2
//    - reduced write: 4
//  - cpu_rdata and ext_rdata each hold their value until that port's next read completes.
//  - Inputs are ignored outside IDLE. A request dropped mid-op does not cancel it; the ack still pulses.
//  - Arbitration: fixed priority, CPU over external, unless CONFIGURATION says otherwise.
// CONFIGURATION
//  - Macro ASRM_ARB_ROUND_ROBIN_EN:
//    - Defined: on simultaneous requests the port not granted last wins.
//      A 1-bit last_grant register tracks this; it resets to ext, so the CPU wins the first tie.
//    - Undefined: CPU always wins ties; the external port can starve.
// STRUCTURE
//  - Shared header asrm_mem_defs.vh holds:
//    - FSM state encodings (IDLE, RD, CAP, WR, ACK)
//    - width codes (WIDTH_FULL/32/16/8)
//    - owner encoding (OWN_CPU, OWN_EXT)
//  - Sub-module asrm_lane_merge: combinational width mask generation, read zero-extension and
//    write merge (old upper bits | new lower bits), parameterised by wordsize.
// TESTING
//  - All tests use wordsize=16.
//  - Full CPU read, addr 0x0010 holding 0xBEEF -> cpu_ack 3 cycles after sample; cpu_rdata=0xBEEF; ram_we stays 0.
//  - Byte CPU write (width 11), addr 0x0020 holding 0x5566, wdata 0x12AB ->
//    one ram_we pulse with ram_data_out=0x55AB; cpu_ack at 4 cycles.
//  - Byte CPU read (width 11) of 0xBEEF -> cpu_rdata=0x00EF.
//    Width 01 write of 0x1234 -> full write, no RD state, ack at 2 cycles.
//  - cpu_req and ext_req both high for 4 back-to-back accesses:
//    - without the macro: grants C,C,C,C
//    - with ASRM_ARB_ROUND_ROBIN_EN: grants C,E,C,E
//  - reset=0 during CAP of a reduced write -> ram_we never asserted, RAM unchanged, all outputs 0, state IDLE.
//  - cpu_req dropped after sample during a read -> access completes; cpu_ack still pulses once at cycle 3.

Source files
------------

// File: rtl/asrm_mem_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: FSM states, width codes, owner encoding.
// Effective-width helpers used by both the arbiter and the lane merge block.
package asrm_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    localparam logic [1:0] WIDTH_FULL = 2'b00;
    localparam logic [1:0] WIDTH_32   = 2'b01;
    localparam logic [1:0] WIDTH_16   = 2'b10;
    localparam logic [1:0] WIDTH_8    = 2'b11;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_EXT = 1'b1;

    // Bit count named by a width code; 0 means full width.
    function automatic int width_bits(input logic [1:0] code);
        int bits;
        case (code)
            WIDTH_32: bits = 32;
            WIDTH_16: bits = 16;
            WIDTH_8:  bits = 8;
            default:  bits = 0;
        endcase
        return bits;
    endfunction

    // A code only narrows the access when it is strictly below the word size.
    function automatic logic is_reduced(input logic [1:0] code, input int ws);
        int bits;
        bits = width_bits(code);
        return (bits != 0) && (bits < ws);
    endfunction

endpackage

// File: rtl/asrm_mem_arbiter_lane_merge.sv
// asrm_lane_merge: width mask, read zero-extension and read-modify-write merge.
module asrm_lane_merge
    import asrm_mem_arbiter_pkg::*;
#(
    parameter int WORDSIZE = 16
) (
    input  logic [1:0]          i_width,
    input  logic [WORDSIZE-1:0] i_old,
    input  logic [WORDSIZE-1:0] i_new,
    output logic [WORDSIZE-1:0] o_rdata,
    output logic [WORDSIZE-1:0] o_merge
);

    logic [WORDSIZE-1:0] w_mask;
    logic                w_reduced;
    int                  w_bits;

    // Low w_bits lanes belong to the access; full width keeps every lane.
    always_comb begin
        w_bits    = width_bits(i_width);
        w_reduced = is_reduced(i_width, WORDSIZE);
        w_mask    = '0;
        for (int i = 0; i < WORDSIZE; i++) begin
            w_mask[i] = (!w_reduced) || (i < w_bits);
        end
    end

    assign o_rdata = i_old & w_mask;
    assign o_merge = (i_old & ~w_mask) | (i_new & w_mask);

endmodule

// File: rtl/asrm_mem_arbiter.sv
// Arbitrates the single synchronous RAM port between CPU and external requester.
// Optional macro ASRM_ARB_ROUND_ROBIN_EN turns fixed CPU priority into alternating tie-break.
module asrm_mem_arbiter
    import asrm_mem_arbiter_pkg::*;
#(
    parameter int wordsize = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [1:0]          cpu_width,
    input  logic [wordsize-1:0] cpu_addr,
    input  logic [wordsize-1:0] cpu_wdata,
    output logic [wordsize-1:0] cpu_rdata,
    output logic                cpu_ack,
    input  logic                ext_req,
    input  logic                ext_we,
    input  logic [wordsize-1:0] ext_addr,
    input  logic [wordsize-1:0] ext_wdata,
    output logic [wordsize-1:0] ext_rdata,
    output logic                ext_ack,
    output logic [wordsize-1:0] ram_addr,
    output logic [wordsize-1:0] ram_data_out,
    output logic                ram_we,
    input  logic [wordsize-1:0] ram_data_in,
    output logic                busy
);

    state_t              r_state;
    logic                r_owner;
    logic                r_we;
    logic [1:0]          r_width;
    logic [wordsize-1:0] r_wdata;
    logic [wordsize-1:0] r_cpu_rdata;
    logic [wordsize-1:0] r_ext_rdata;
    logic                r_cpu_ack;
    logic                r_ext_ack;
    logic [wordsize-1:0] r_ram_addr;
    logic [wordsize-1:0] r_ram_data_out;
    logic                r_ram_we;
    logic                r_busy;
`ifdef ASRM_ARB_ROUND_ROBIN_EN
    logic                r_last_grant;
`endif

    logic                w_grant_ext;
    logic                w_sel_we;
    logic [1:0]          w_sel_width;
    logic [wordsize-1:0] w_sel_addr;
    logic [wordsize-1:0] w_sel_wdata;
    logic                w_sel_reduced;
    logic [wordsize-1:0] w_rd_masked;
    logic [wordsize-1:0] w_merge;

    // Owner selection and request mux for the IDLE sample.
    always_comb begin
        w_grant_ext = 1'b0;
        if (cpu_req && ext_req) begin
`ifdef ASRM_ARB_ROUND_ROBIN_EN
            w_grant_ext = (r_last_grant == OWN_CPU);
`else
            w_grant_ext = 1'b0;
`endif
        end else if (ext_req) begin
            w_grant_ext = 1'b1;
        end else begin
            w_grant_ext = 1'b0;
        end
        w_sel_we      = w_grant_ext ? ext_we    : cpu_we;
        w_sel_width   = w_grant_ext ? WIDTH_FULL : cpu_width;
        w_sel_addr    = w_grant_ext ? ext_addr  : cpu_addr;
        w_sel_wdata   = w_grant_ext ? ext_wdata : cpu_wdata;
        w_sel_reduced = is_reduced(w_sel_width, wordsize);
    end

    asrm_lane_merge #(.WORDSIZE(wordsize)) u_lane_merge (
        .i_width (r_width),
        .i_old   (ram_data_in),
        .i_new   (r_wdata),
        .o_rdata (w_rd_masked),
        .o_merge (w_merge)
    );

    // Access sequencer; every RAM-facing and CPU-facing output is registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_owner        <= OWN_CPU;
            r_we           <= 1'b0;
            r_width        <= WIDTH_FULL;
            r_wdata        <= '0;
            r_cpu_rdata    <= '0;
            r_ext_rdata    <= '0;
            r_cpu_ack      <= 1'b0;
            r_ext_ack      <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_data_out <= '0;
            r_ram_we       <= 1'b0;
            r_busy         <= 1'b0;
`ifdef ASRM_ARB_ROUND_ROBIN_EN
            r_last_grant   <= OWN_EXT;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req || ext_req) begin
                        r_owner    <= w_grant_ext ? OWN_EXT : OWN_CPU;
                        r_we       <= w_sel_we;
                        r_width    <= w_sel_width;
                        r_wdata    <= w_sel_wdata;
                        r_ram_addr <= w_sel_addr;
                        r_busy     <= 1'b1;
`ifdef ASRM_ARB_ROUND_ROBIN_EN
                        r_last_grant <= w_grant_ext ? OWN_EXT : OWN_CPU;
`endif
                        if (!w_sel_we || w_sel_reduced) begin
                            r_state <= ST_RD;
                        end else begin
                            r_state        <= ST_WR;
                            r_ram_data_out <= w_sel_wdata;
                            r_ram_we       <= 1'b1;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_RD: begin
                    r_state <= ST_CAP;
                end
                ST_CAP: begin
                    if (!r_we) begin
                        r_state <= ST_ACK;
                        if (r_owner == OWN_EXT) begin
                            r_ext_rdata <= w_rd_masked;
                            r_ext_ack   <= 1'b1;
                        end else begin
                            r_cpu_rdata <= w_rd_masked;
                            r_cpu_ack   <= 1'b1;
                        end
                    end else begin
                        r_state        <= ST_WR;
                        r_ram_data_out <= w_merge;
                        r_ram_we       <= 1'b1;
                    end
                end
                ST_WR: begin
                    r_state   <= ST_ACK;
                    r_ram_we  <= 1'b0;
                    r_cpu_ack <= (r_owner == OWN_CPU);
                    r_ext_ack <= (r_owner == OWN_EXT);
                end
                ST_ACK: begin
                    r_state   <= ST_IDLE;
                    r_cpu_ack <= 1'b0;
                    r_ext_ack <= 1'b0;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_ram_we  <= 1'b0;
                    r_cpu_ack <= 1'b0;
                    r_ext_ack <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rdata    = r_cpu_rdata;
    assign cpu_ack      = r_cpu_ack;
    assign ext_rdata    = r_ext_rdata;
    assign ext_ack      = r_ext_ack;
    assign ram_addr     = r_ram_addr;
    assign ram_data_out = r_ram_data_out;
    assign ram_we       = r_ram_we;
    assign busy         = r_busy;

endmodule

// File: tb/tb_asrm_mem_arbiter.sv
// Directed self-checking bench for asrm_mem_arbiter (wordsize 16) with a behavioural synchronous RAM.
module tb_asrm_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [1:0]  cpu_width = 2'b00;
    logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        ext_req = 1'b0, ext_we = 1'b0;
    logic [15:0] ext_addr = 16'h0, ext_wdata = 16'h0;
    logic [15:0] ext_rdata;
    logic        ext_ack;
    logic [15:0] ram_addr, ram_data_out, ram_data_in;
    logic        ram_we;
    logic        busy;

    logic [15:0] mem [256];
    int          n_checks = 0;
    int          n_fail = 0;
    int          we_count = 0;
    int          cpu_ack_count = 0;
    logic [15:0] last_we_data = 16'h0;

    asrm_mem_arbiter #(.wordsize(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_width(cpu_width),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_we(ram_we),
        .ram_data_in(ram_data_in), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data for an address appears the cycle after it is presented.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_data_out;
        ram_data_in <= mem[ram_addr[7:0]];
    end

    // Count strobes and acks mid-cycle.
    always @(negedge clk) begin
        if (ram_we) begin
            we_count++;
            last_we_data = ram_data_out;
        end
        if (cpu_ack) cpu_ack_count++;
    end

    task automatic run_cpu(input logic we, input logic [1:0] width, input logic [15:0] addr,
                           input logic [15:0] wdata, input bit drop_early, output int lat);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_width = width; cpu_addr = addr; cpu_wdata = wdata;
        lat = 99;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (n == 1 && drop_early) cpu_req = 1'b0;
            if (cpu_ack) begin
                lat = n;
                break;
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (cpu_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_cpu_rdata got %h want 0000", cpu_rdata); end
        n_checks++; if (ext_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_ext_rdata got %h want 0000", ext_rdata); end
        n_checks++; if ({cpu_ack, ext_ack, ram_we, busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {cpu_ack, ext_ack, ram_we, busy}); end
        n_checks++; if ({ram_addr, ram_data_out} !== 32'h0) begin n_fail++; $display("FAIL reset_ram_bus got %h want 00000000", {ram_addr, ram_data_out}); end
        reset = 1'b1;
    endtask

    task automatic test_full_read();
        int lat, we0;
        we0 = we_count;
        run_cpu(1'b0, 2'b00, 16'h0010, 16'h0, 1'b0, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL full_read_latency got %0d want 3", lat); end
        n_checks++; if (cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL full_read_data got %h want beef", cpu_rdata); end
        n_checks++; if (we_count !== we0) begin n_fail++; $display("FAIL full_read_no_we got %0d want %0d", we_count, we0); end
        @(posedge clk); #1;
        n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL full_read_ack_width got %b want 0", cpu_ack); end
    endtask

    task automatic test_byte_write();
        int lat, we0;
        we0 = we_count;
        run_cpu(1'b1, 2'b11, 16'h0020, 16'h12AB, 1'b0, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL byte_write_latency got %0d want 4", lat); end
        n_checks++; if (we_count !== we0 + 1) begin n_fail++; $display("FAIL byte_write_we_pulses got %0d want %0d", we_count - we0, 1); end
        n_checks++; if (last_we_data !== 16'h55AB) begin n_fail++; $display("FAIL byte_write_merge got %h want 55ab", last_we_data); end
        n_checks++; if (mem[8'h20] !== 16'h55AB) begin n_fail++; $display("FAIL byte_write_ram got %h want 55ab", mem[8'h20]); end
    endtask

    task automatic test_width_reads();
        int lat;
        run_cpu(1'b0, 2'b10, 16'h0010, 16'h0, 1'b0, lat);
        n_checks++; if (cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL width16_read_data got %h want beef", cpu_rdata); end
        run_cpu(1'b0, 2'b11, 16'h0010, 16'h0, 1'b0, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL byte_read_latency got %0d want 3", lat); end
        n_checks++; if (cpu_rdata !== 16'h00EF) begin n_fail++; $display("FAIL byte_read_data got %h want 00ef", cpu_rdata); end
    endtask

    task automatic test_width01_write();
        int lat, we0;
        we0 = we_count;
        run_cpu(1'b1, 2'b01, 16'h0030, 16'h1234, 1'b0, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL w01_write_latency got %0d want 2", lat); end
        n_checks++; if (we_count !== we0 + 1 || last_we_data !== 16'h1234) begin n_fail++; $display("FAIL w01_write_strobe got %0d/%h want 1/1234", we_count - we0, last_we_data); end
        n_checks++; if (mem[8'h30] !== 16'h1234) begin n_fail++; $display("FAIL w01_write_ram got %h want 1234", mem[8'h30]); end
    endtask

    task automatic test_ext_read();
        int lat;
        @(posedge clk); #1;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0020;
        lat = 99;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (ext_ack) begin lat = n; break; end
        end
        ext_req = 1'b0;
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL ext_read_latency got %0d want 3", lat); end
        n_checks++; if (ext_rdata !== 16'h55AB) begin n_fail++; $display("FAIL ext_read_data got %h want 55ab", ext_rdata); end
        n_checks++; if (cpu_rdata !== 16'h00EF) begin n_fail++; $display("FAIL cpu_rdata_hold got %h want 00ef", cpu_rdata); end
    endtask

    task automatic test_req_drop();
        int lat, a0;
        a0 = cpu_ack_count;
        run_cpu(1'b0, 2'b00, 16'h0010, 16'h0, 1'b1, lat);
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL drop_latency got %0d want 3", lat); end
        n_checks++; if (cpu_ack_count !== a0 + 1) begin n_fail++; $display("FAIL drop_ack_count got %0d want 1", cpu_ack_count - a0); end
        n_checks++; if (cpu_rdata !== 16'hBEEF || busy !== 1'b0) begin n_fail++; $display("FAIL drop_final got %h/%b want beef/0", cpu_rdata, busy); end
    endtask

    task automatic test_reset_mid_rmw();
        int we0;
        mem[8'h40] = 16'hA5A5;
        we0 = we_count;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_width = 2'b11; cpu_addr = 16'h0040; cpu_wdata = 16'h0033;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; cpu_req = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({cpu_ack, ext_ack, ram_we, busy} !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_flags got %b want 0000", {cpu_ack, ext_ack, ram_we, busy}); end
        n_checks++; if ({cpu_rdata, ext_rdata, ram_addr, ram_data_out} !== 64'h0) begin n_fail++; $display("FAIL mid_reset_buses got %h want 0", {cpu_rdata, ext_rdata, ram_addr, ram_data_out}); end
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (we_count !== we0) begin n_fail++; $display("FAIL mid_reset_no_we got %0d want %0d", we_count, we0); end
        n_checks++; if (mem[8'h40] !== 16'hA5A5) begin n_fail++; $display("FAIL mid_reset_ram got %h want a5a5", mem[8'h40]); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_idle got %b want 0", busy); end
    endtask

    task automatic test_arbitration();
        logic exp_ext [4];
        logic got_ext;
`ifdef ASRM_ARB_ROUND_ROBIN_EN
        exp_ext = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ext = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_width = 2'b00; cpu_addr = 16'h0010;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            got_ext = 1'bx;
            for (int n = 1; n <= 12; n++) begin
                @(posedge clk); #1;
                if (cpu_ack && ext_ack) begin
                    n_fail++; $display("FAIL arb_dual_ack access %0d got both want one", k);
                end
                if (cpu_ack || ext_ack) begin
                    got_ext = ext_ack;
                    break;
                end
            end
            if (k == 3) begin cpu_req = 1'b0; ext_req = 1'b0; end
            n_checks++;
            if (got_ext !== exp_ext[k]) begin
                n_fail++; $display("FAIL arb_grant access %0d got ext=%b want ext=%b", k, got_ext, exp_ext[k]);
            end
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h10] = 16'hBEEF;
        mem[8'h20] = 16'h5566;
        test_reset();
        test_full_read();
        test_byte_write();
        test_width_reads();
        test_width01_write();
        test_ext_read();
        test_req_drop();
        test_reset_mid_rmw();
        test_arbitration();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
